// File: rtl/truth_table_scanner_pkg.sv
// tt_pkg: shared states and exercise truth tables for the scanner
package tt_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
  localparam int N_IN_DEF = 3;
  localparam int ROWS = 2**N_IN_DEF;
  localparam logic [ROWS-1:0] TT_FXYZ_D = 8'h8A;
  localparam logic [ROWS-1:0] TT_ALL1 = 8'hFF;
  localparam logic [ROWS-1:0] TT_ALL0 = 8'h00;
endpackage

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: stimulus/response bundle between scanner and function under test
interface truth_table_scanner_if #(parameter int N_IN = 3);
  logic start;
  logic [N_IN-1:0] stim;
  logic s_in;
  logic busy;
  logic done;
  logic [2**N_IN-1:0] table_out;
  logic match;
  logic [N_IN:0] err_count;
  logic [N_IN-1:0] first_err;
  modport master(output start, s_in, input stim, busy, done, table_out, match, err_count, first_err);
  modport slave(input start, s_in, output stim, busy, done, table_out, match, err_count, first_err);
endinterface

// File: rtl/truth_table_scanner_row_counter.sv
// tt_row_counter: row index and per-row settle counters for the scan
module tt_row_counter #(
  parameter int N_IN = 3,
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_settle_inc,
  input  logic i_row_inc,
  output logic [N_IN-1:0] o_idx,
  output logic o_row_last,
  output logic o_settle_last
);
  localparam logic [N_IN:0] ROW_ONE = 1;
  localparam logic [N_IN:0] ROW_LAST = (N_IN+1)'(2**N_IN-1);
  logic [N_IN:0] r_row;
  logic [3:0] r_settle;
  // Advancing a row restarts its settle window; clear restarts the whole sweep
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_row <= '0;
      r_settle <= '0;
    end else if (i_row_inc) begin
      r_row <= r_row + ROW_ONE;
      r_settle <= '0;
    end else if (i_settle_inc) begin
      r_settle <= r_settle + 4'd1;
    end
  end
  assign o_idx = r_row[N_IN-1:0];
  assign o_row_last = r_row == ROW_LAST;
  assign o_settle_last = r_settle == 4'(SETTLE-1);
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps all input rows of a function and checks it against a table
module truth_table_scanner import tt_pkg::*; #(
  parameter int N_IN = 3,
  parameter int SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECTED = TT_FXYZ_D
) (
  input logic clk,
  input logic reset,
  truth_table_scanner_if.slave bus
);
  localparam logic [N_IN:0] ERR_ONE = 1;
  state_t r_state, w_next;
  logic w_clr, w_settle_inc, w_row_inc, w_row_last, w_settle_last, w_miss;
  logic [N_IN-1:0] w_idx;
  logic [2**N_IN-1:0] r_table;
  logic [N_IN:0] r_err;
  logic [N_IN-1:0] r_first;
  tt_row_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
    .clk(clk),
    .reset(reset),
    .i_clr(w_clr),
    .i_settle_inc(w_settle_inc),
    .i_row_inc(w_row_inc),
    .o_idx(w_idx),
    .o_row_last(w_row_last),
    .o_settle_last(w_settle_last)
  );
  // State register; reset aborts any scan in flight
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state and counter controls; start is only honoured when not busy
  always_comb begin
    w_next = r_state;
    w_clr = 1'b0;
    w_settle_inc = 1'b0;
    w_row_inc = 1'b0;
    case (r_state)
      IDLE, DONE: if (bus.start) begin
        w_next = APPLY;
        w_clr = 1'b1;
      end
      APPLY: begin
        w_settle_inc = 1'b1;
        w_next = w_settle_last ? CAPTURE : APPLY;
      end
      CAPTURE: begin
        w_row_inc = !w_row_last;
        w_next = w_row_last ? DONE : APPLY;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_miss = bus.s_in != EXPECTED[w_idx];
  // Capture the settled response and tally mismatches, remembering the first one
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_table <= '0;
      r_err <= '0;
      r_first <= '0;
    end else if (r_state == CAPTURE) begin
      r_table[w_idx] <= bus.s_in;
      if (w_miss) r_err <= r_err + ERR_ONE;
      if (w_miss && r_err == '0) r_first <= w_idx;
    end
  end
  assign bus.busy = r_state == APPLY || r_state == CAPTURE;
  assign bus.done = r_state == DONE;
  assign bus.stim = bus.busy ? w_idx : '0;
  assign bus.table_out = r_table;
  assign bus.err_count = r_err;
  assign bus.first_err = r_first;
  assign bus.match = bus.done && r_err == '0;
endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Self-checking scan stage that sits directly upstream of a combinational logic block and also consumes its output.
- Drives every input combination of an N_IN-input function in ascending order and waits a settle time per row.
- Captures the function output into a truth-table vector and compares it bit-wise against an expected table.
- Replaces hand-written #1 stimulus sequences with a clocked, reusable sweeper for the team's gate-level exercises.

Parameters:
- N_IN, 3, number of function inputs; rows = 2**N_IN.
- SETTLE, 1, cycles the stimulus is held before capture (legal range 1..15).
- EXPECTED, 8'h8A, expected table, bit i = output for row i. The default encodes s = ~(x & ~y) & z with row index {x,y,z}; its minterms are 1, 3 and 7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a scan.
- stim  output  N_IN  current input combination; MSB = first input (x).
- s_in  input  1  output of the function under test.
- busy  output  1  high while a scan is in progress.
- done  output  1  high while results are valid; held until the next start or reset.
- table_out  output  2**N_IN  captured truth table, bit i = row i.
- match  output  1  1 when table_out == EXPECTED; valid only while done=1.
- err_count  output  N_IN+1  number of mismatching rows.
- first_err  output  N_IN  lowest mismatching row index; 0 if there are none.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: stim=0, busy=0, done=0, table_out=0, match=0, err_count=0, first_err=0; FSM goes to IDLE and counters clear.
- Reset mid-scan aborts immediately. Partial results are discarded and no done pulse is produced.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
  - IDLE: stim=0. start=1 -> APPLY with row=0, settle counter=0, table_out/err_count/first_err cleared. busy=1 from the next cycle.
  - APPLY: stim=row, held stable. The settle counter increments each cycle; when it reaches SETTLE-1 -> CAPTURE.
  - CAPTURE: stim=row, still held. At the closing edge, s_in is registered into table_out[row].
    - If s_in != EXPECTED[row]: err_count increments; first_err is loaded if this is the first mismatch.
    - If row == 2**N_IN-1 -> DONE. Otherwise row increments, the settle counter clears, and the FSM goes back to APPLY.
  - DONE: busy=0, done=1, stim=0. match = (err_count==0). Results are held.
    - start=1 -> APPLY (restart); done drops the next cycle and results clear.
- Each row takes SETTLE+1 cycles. A full scan takes 2**N_IN*(SETTLE+1) cycles from the first APPLY cycle to the last CAPTURE cycle.
- done rises on the cycle after the last CAPTURE. With defaults that is 16 cycles after the APPLY entry.
- start while busy=1 is ignored and does not restart.
- start and reset in the same cycle: reset wins.
- Row counter width N_IN+1 so the terminal compare does not wrap. The stim output uses the low N_IN bits.
- err_count saturates naturally: its maximum, 2**N_IN, fits in N_IN+1 bits.
- s_in is treated as a 0/1 signal. The bench must never leave it unknown during CAPTURE.

Decomposition:
- Shared package tt_pkg:
  - state enum {IDLE, APPLY, CAPTURE, DONE}, 2-bit encoding.
  - localparam ROWS = 2**N_IN.
  - named constants for the exercise tables, e.g. TT_FXYZ_D = 8'h8A.
- One sub-module, tt_row_counter:
  - row and settle counters with load/clear/increment.
  - outputs row_last and settle_last.
  - The FSM and compare logic stay in the top.

Test Plan:
- Golden run: combinational model s = ~(x & ~y) & z on stim, defaults, start pulse -> stim steps 0..7 every 2 cycles. Then done=1 with table_out=8'h8A, match=1, err_count=0, first_err=0.
- Stuck-at-1 on s_in -> table_out=8'hFF, err_count=5, first_err=0, match=0.
- Stuck-at-0 on s_in -> table_out=8'h00, err_count=3, first_err=1, match=0.
- SETTLE=3 golden run -> each stim value held 4 cycles. done asserts exactly 32 cycles after APPLY entry, with table_out=8'h8A.
- Reset asserted while stim=4 -> next cycle all outputs are at reset values and done stays 0. A following start produces a full, correct scan.
- start pulsed at stim=2 mid-scan -> no restart, single done, results unchanged. start pulsed during DONE -> done drops, table_out clears, and a new scan completes with identical results.
